// File: rtl/frame_timing_gen_pkg.sv
// Shared frame timing definitions: FSM state encodings and default timing
// constants, also imported by downstream pattern stages.
package frame_timing_gen_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FGAP   = 3'd1;
    localparam logic [2:0] ST_VFRONT = 3'd2;
    localparam logic [2:0] ST_LINE   = 3'd3;
    localparam logic [2:0] ST_LGAP   = 3'd4;
    localparam logic [2:0] ST_VBACK  = 3'd5;

    localparam int unsigned DEF_DVAL_HIGH = 640;
    localparam int unsigned DEF_ROW_COUNT = 480;
    localparam int unsigned DEF_H_FRONT   = 4;
    localparam int unsigned DEF_H_BACK    = 4;
    localparam int unsigned DEF_LINE_GAP  = 16;
    localparam int unsigned DEF_V_FRONT   = 8;
    localparam int unsigned DEF_V_BACK    = 8;
    localparam int unsigned DEF_FRAME_GAP = 32;

    // True when lo <= v < lo + len.
    function automatic logic in_window(input logic [31:0] v, input logic [31:0] lo,
                                       input logic [31:0] len);
        return (v >= lo) && (v < lo + len);
    endfunction

endpackage

// File: rtl/frame_timing_gen.sv
// Camera-style frame timing generator producing fval/lval/dval, edge pulses
// and a completed-frame counter. Every output is registered.
module frame_timing_gen
    import frame_timing_gen_pkg::*;
#(
    parameter int unsigned DVAL_HIGH = DEF_DVAL_HIGH,
    parameter int unsigned ROW_COUNT = DEF_ROW_COUNT,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned LINE_GAP  = DEF_LINE_GAP,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter int unsigned FRAME_GAP = DEF_FRAME_GAP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        fval,
    output logic        lval,
    output logic        dval,
    output logic        fval_posedge,
    output logic        lval_negedge,
    output logic [15:0] frame_cnt,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    localparam logic [31:0] LINE_LEN = 32'(H_FRONT + DVAL_HIGH + H_BACK);

    logic [2:0]  state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [31:0] line_cnt, line_cnt_nxt;

    // en is only looked at in IDLE and when VBACK ends, so a frame in
    // progress always runs to completion.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + 32'd1;
        line_cnt_nxt = line_cnt;
        case (state)
            ST_IDLE: begin
                cnt_nxt = 32'd0;
                if (en) state_nxt = ST_FGAP;
            end
            ST_FGAP: begin
                if (cnt == 32'(FRAME_GAP - 1)) begin
                    state_nxt    = ST_VFRONT;
                    cnt_nxt      = 32'd0;
                    line_cnt_nxt = 32'd0;
                end
            end
            ST_VFRONT: begin
                if (cnt == 32'(V_FRONT - 1)) begin
                    state_nxt = ST_LINE;
                    cnt_nxt   = 32'd0;
                end
            end
            ST_LINE: begin
                if (cnt == LINE_LEN - 32'd1) begin
                    cnt_nxt      = 32'd0;
                    line_cnt_nxt = line_cnt + 32'd1;
                    state_nxt    = (line_cnt + 32'd1 < 32'(ROW_COUNT)) ? ST_LGAP : ST_VBACK;
                end
            end
            ST_LGAP: begin
                if (cnt == 32'(LINE_GAP - 1)) begin
                    state_nxt = ST_LINE;
                    cnt_nxt   = 32'd0;
                end
            end
            ST_VBACK: begin
                if (cnt == 32'(V_BACK - 1)) begin
                    state_nxt = en ? ST_FGAP : ST_IDLE;
                    cnt_nxt   = 32'd0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 32'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up cycle-for-cycle
    // with the registered state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cnt          <= 32'd0;
            line_cnt     <= 32'd0;
            fval         <= 1'b0;
            lval         <= 1'b0;
            dval         <= 1'b0;
            fval_posedge <= 1'b0;
            lval_negedge <= 1'b0;
            busy         <= 1'b0;
            frame_cnt    <= 16'd0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            line_cnt     <= line_cnt_nxt;
            fval         <= (state_nxt != ST_IDLE) && (state_nxt != ST_FGAP);
            lval         <= (state_nxt == ST_LINE);
            dval         <= (state_nxt == ST_LINE) &&
                            in_window(cnt_nxt, 32'(H_FRONT), 32'(DVAL_HIGH));
            fval_posedge <= (state == ST_FGAP) && (state_nxt == ST_VFRONT);
            lval_negedge <= (state == ST_LINE) && (state_nxt != ST_LINE);
            busy         <= (state_nxt != ST_IDLE);
            if ((state_nxt == ST_VBACK) && (cnt_nxt == 32'(V_BACK - 1)))
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_frame_timing_gen.sv
// Directed bench for frame_timing_gen using the small verification geometry
// (8x4 pixels, 62-cycle frame period).
module tb_frame_timing_gen;
    import frame_timing_gen_pkg::*;

    localparam int unsigned P_DVAL_HIGH = 8;
    localparam int unsigned P_ROW_COUNT = 4;
    localparam int unsigned P_H_FRONT   = 2;
    localparam int unsigned P_H_BACK    = 1;
    localparam int unsigned P_LINE_GAP  = 3;
    localparam int unsigned P_V_FRONT   = 2;
    localparam int unsigned P_V_BACK    = 2;
    localparam int unsigned P_FRAME_GAP = 5;
    localparam int PERIOD = 62;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        fval, lval, dval, fval_posedge, lval_negedge, busy;
    logic [15:0] frame_cnt;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    frame_timing_gen #(
        .DVAL_HIGH(P_DVAL_HIGH), .ROW_COUNT(P_ROW_COUNT), .H_FRONT(P_H_FRONT),
        .H_BACK(P_H_BACK), .LINE_GAP(P_LINE_GAP), .V_FRONT(P_V_FRONT),
        .V_BACK(P_V_BACK), .FRAME_GAP(P_FRAME_GAP)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .fval(fval), .lval(lval), .dval(dval),
        .fval_posedge(fval_posedge), .lval_negedge(lval_negedge),
        .frame_cnt(frame_cnt), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Holds reset for two cycles, then releases it at a falling edge with en applied.
    task automatic do_reset(input logic en_val);
        rst = 1'b0;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        en  = en_val;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b0;
        #1;
        checks++;
        if ({fval, lval, dval, fval_posedge, lval_negedge, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 000000",
                     {fval, lval, dval, fval_posedge, lval_negedge, busy});
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt: got %h, want 0000", frame_cnt);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d, want %0d", dbg_state, ST_IDLE);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, fval, dbg_state} !== {1'b0, 1'b0, ST_IDLE}) begin
            errors++;
            $display("FAIL idle_hold: busy=%b fval=%b state=%0d, want 0 0 %0d",
                     busy, fval, dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_first_frame();
        logic f [0:PERIOD-1];
        logic l [0:PERIOD-1];
        logic d [0:PERIOD-1];
        logic ln [0:PERIOD-1];
        logic fp [0:PERIOD-1];
        int k, bad, n_ln, n_fp, n_d;
        en = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k++;
            if (fval_posedge === 1'b1) break;
        end
        checks++;
        if (k !== 6) begin
            errors++;
            $display("FAIL start_latency: fval_posedge after %0d cycles, want 6", k);
        end
        for (int i = 0; i < PERIOD; i++) begin
            f[i] = fval; l[i] = lval; d[i] = dval; ln[i] = lval_negedge; fp[i] = fval_posedge;
            @(negedge clk);
        end
        checks++;
        if (fval_posedge !== 1'b1) begin
            errors++;
            $display("FAIL frame_period: fval_posedge=%b at cycle 62, want 1", fval_posedge);
        end
        bad = 0;
        for (int i = 0; i < PERIOD; i++)
            if (f[i] !== (i < 57)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL fval_shape: %0d cycles wrong, want 57 high then 5 low", bad);
        end
        for (int j = 0; j < 4; j++) begin
            bad = 0;
            for (int o = 0; o < 14; o++) begin
                if (l[2 + 14*j + o] !== (o < 11)) bad++;
                if (d[2 + 14*j + o] !== (o >= 2 && o < 10)) bad++;
                if (ln[2 + 14*j + o] !== (o == 11)) bad++;
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL line%0d_shape: %0d samples wrong, want 0", j, bad);
            end
        end
        n_ln = 0; n_fp = 0; n_d = 0;
        for (int i = 0; i < PERIOD; i++) begin
            n_ln += int'(ln[i]);
            n_fp += int'(fp[i]);
            n_d  += int'(d[i]);
        end
        checks++;
        if ({n_ln, n_fp, n_d} !== {32'd4, 32'd1, 32'd32}) begin
            errors++;
            $display("FAIL frame_pulses: lval_negedge=%0d fval_posedge=%0d dval=%0d, want 4 1 32",
                     n_ln, n_fp, n_d);
        end
    endtask

    task automatic test_three_frames();
        int n_fp, n_ln, viol;
        do_reset(1'b1);
        n_fp = 0; n_ln = 0; viol = 0;
        for (int i = 0; i < 3*PERIOD; i++) begin
            @(negedge clk);
            n_fp += int'(fval_posedge);
            n_ln += int'(lval_negedge);
            if ((dval && !lval) || (lval && !fval)) viol++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n_fp !== 3) begin
            errors++;
            $display("FAIL three_fval_posedge: got %0d, want 3", n_fp);
        end
        checks++;
        if (n_ln !== 12) begin
            errors++;
            $display("FAIL three_lval_negedge: got %0d, want 12", n_ln);
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL invariants: %0d violating cycles, want 0", viol);
        end
        checks++;
        if (frame_cnt !== 16'd3) begin
            errors++;
            $display("FAIL three_frame_cnt: got %0d, want 3", frame_cnt);
        end
    endtask

    task automatic test_en_drop();
        int rises, n_ln, n_fhi, n_fp, busy_seen;
        logic prev_l, done;
        do_reset(1'b1);
        rises = 0; n_ln = 0; n_fhi = 0; prev_l = 1'b0; done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (lval && !prev_l) rises++;
            prev_l = lval;
            if (rises == 2) en = 1'b0;
            n_ln  += int'(lval_negedge);
            n_fhi += int'(fval);
            if (i > 2 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL en_drop_timeout: busy still %b after 300 cycles, want 0", busy);
        end
        checks++;
        if ({n_ln, n_fhi, 31'd0, fval} !== {32'd4, 32'd57, 32'd0}) begin
            errors++;
            $display("FAIL en_drop_frame: lval_negedge=%0d fval_cycles=%0d fval=%b, want 4 57 0",
                     n_ln, n_fhi, fval);
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL en_drop_frame_cnt: got %0d, want 1", frame_cnt);
        end
        n_fp = 0; busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_fp += int'(fval_posedge);
            busy_seen += int'(busy);
        end
        checks++;
        if ({n_fp, busy_seen} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL en_drop_idle: fval_posedge=%0d busy_cycles=%0d, want 0 0",
                     n_fp, busy_seen);
        end
    endtask

    task automatic test_reset_mid_line();
        int k;
        logic hit;
        do_reset(1'b1);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dval) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL mid_line_dval_timeout: dval=%b after 100 cycles, want 1", dval);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({fval, lval, dval, fval_posedge, lval_negedge, busy, frame_cnt} !== 22'd0) begin
            errors++;
            $display("FAIL mid_line_reset: outputs %b cnt=%h, want all 0",
                     {fval, lval, dval, fval_posedge, lval_negedge, busy}, frame_cnt);
        end
        @(negedge clk);
        en  = 1'b1;
        rst = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k++;
            if (fval_posedge === 1'b1) break;
        end
        checks++;
        if (k !== 6) begin
            errors++;
            $display("FAIL restart_latency: fval_posedge after %0d cycles, want 6", k);
        end
    endtask

    task automatic test_wrap();
        logic prev_f, hit;
        do_reset(1'b1);
        repeat (2) @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        checks++;
        if (frame_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: got %h, want ffff", frame_cnt);
        end
        prev_f = 1'b0; hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (prev_f && !fval) begin
                hit = 1'b1;
                break;
            end
            prev_f = fval;
        end
        checks++;
        if ({hit, frame_cnt} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL wrap: frame_end=%b frame_cnt=%h, want 1 0000", hit, frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_three_frames();
        test_en_drop();
        test_reset_mid_line();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
